// File: rtl/rh_axi4_aw_arbiter.sv
// Round-robin arbiter sharing one AXI4 AW channel among NREQ requesters, with a
// grant-order FIFO for the W mux. Define RH_AXI4_AW_ARB_QOS_EN for QOS-first arbitration.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no AW outstanding; arbitrate when a request is valid and FIFO not full
// ST_HOLD | M_AW payload registered and presented; wait for M_AWREADY
module rh_axi4_aw_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int AW        = 32,
    parameter  int IW        = 4,
    parameter  int ORD_DEPTH = 8,
    localparam int NW        = $clog2(NREQ),
    localparam int ATTR      = 29
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [NREQ-1:0]      S_AWVALID,
    output logic [NREQ-1:0]      S_AWREADY,
    input  logic [NREQ*IW-1:0]   S_AWID,
    input  logic [NREQ*AW-1:0]   S_AWADDR,
    input  logic [NREQ*ATTR-1:0] S_AWATTR,
    output logic                 M_AWVALID,
    input  logic                 M_AWREADY,
    output logic [IW+NW-1:0]     M_AWID,
    output logic [AW-1:0]        M_AWADDR,
    output logic [ATTR-1:0]      M_AWATTR,
    output logic                 ORD_VALID,
    output logic [NW-1:0]        ORD_IDX,
    input  logic                 ORD_POP,
    output logic                 ERR_VLD_DROP
);

    localparam int PW = $clog2(ORD_DEPTH);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;
    localparam logic [NW-1:0] LAST_IDX = NW'(NREQ - 1);

    logic            state;
    logic [NW-1:0]   rr_ptr;
    logic [NW-1:0]   grant;
    logic [NW-1:0]   pick;
    logic            pick_vld;
    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   sel_id;
    logic [AW-1:0]   sel_addr;
    logic [ATTR-1:0] sel_attr;
    logic            handshake;

    logic [NW-1:0]   ord_mem [ORD_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     rd_next;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [NW-1:0]   ord_head;

`ifdef RH_AXI4_AW_ARB_QOS_EN
    // QOS sits at ATTR[7:4]; only the highest QOS among valid requesters competes.
    logic [3:0] max_qos;
    always_comb begin
        max_qos  = '0;
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (S_AWVALID[i] && (S_AWATTR[i*ATTR+4 +: 4] > max_qos))
                max_qos = S_AWATTR[i*ATTR+4 +: 4];
        end
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = S_AWVALID[i] && (S_AWATTR[i*ATTR+4 +: 4] == max_qos);
        end
    end
`else
    assign eligible = S_AWVALID;
`endif

    // First eligible index at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!pick_vld && eligible[idx]) begin
                pick     = idx[NW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_attr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == i[NW-1:0]) begin
                sel_id   = S_AWID[i*IW +: IW];
                sel_addr = S_AWADDR[i*AW +: AW];
                sel_attr = S_AWATTR[i*ATTR +: ATTR];
            end
        end
    end

    assign handshake = (state == ST_HOLD) && M_AWVALID && M_AWREADY;

    always_comb begin
        S_AWREADY = '0;
        if (handshake)
            S_AWREADY[grant] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            M_AWVALID    <= 1'b0;
            M_AWID       <= '0;
            M_AWADDR     <= '0;
            M_AWATTR     <= '0;
            ERR_VLD_DROP <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld && !fifo_full) begin
                        M_AWVALID <= 1'b1;
                        M_AWID    <= {pick, sel_id};
                        M_AWADDR  <= sel_addr;
                        M_AWATTR  <= sel_attr;
                        grant     <= pick;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // The captured burst completes regardless; the drop is only flagged.
                    if (!S_AWVALID[grant])
                        ERR_VLD_DROP <= 1'b1;
                    if (M_AWREADY) begin
                        M_AWVALID <= 1'b0;
                        rr_ptr    <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign push       = handshake;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop        = ORD_POP && !fifo_empty;
    assign rd_next    = rd_ptr + 1'b1;

    always_ff @(posedge ACLK) begin
        if (push)
            ord_mem[wr_ptr[PW-1:0]] <= grant;
    end

    // ord_head mirrors the entry at rd_ptr so ORD_IDX comes straight from a flop.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ord_head <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_next;
                if (rd_next != wr_ptr)
                    ord_head <= ord_mem[rd_next[PW-1:0]];
                else if (push)
                    ord_head <= grant;
            end else if (push && fifo_empty) begin
                ord_head <= grant;
            end
        end
    end

    assign ORD_VALID = !fifo_empty;
    assign ORD_IDX   = ord_head;

endmodule

// File: tb/tb_rh_axi4_aw_arbiter.sv
// Self-checking bench for rh_axi4_aw_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level model (grant queue, RR pointer).
module tb_rh_axi4_aw_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int DEP  = 8;
    localparam int NW   = 2;
    localparam int AT   = 29;

    logic                 ACLK;
    logic                 ARESETN;
    logic [NREQ-1:0]      S_AWVALID;
    logic [NREQ-1:0]      S_AWREADY;
    logic [NREQ*IW-1:0]   S_AWID;
    logic [NREQ*AW-1:0]   S_AWADDR;
    logic [NREQ*AT-1:0]   S_AWATTR;
    logic                 M_AWVALID;
    logic                 M_AWREADY;
    logic [IW+NW-1:0]     M_AWID;
    logic [AW-1:0]        M_AWADDR;
    logic [AT-1:0]        M_AWATTR;
    logic                 ORD_VALID;
    logic [NW-1:0]        ORD_IDX;
    logic                 ORD_POP;
    logic                 ERR_VLD_DROP;

    rh_axi4_aw_arbiter #(.NREQ(NREQ), .AW(AW), .IW(IW), .ORD_DEPTH(DEP)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID),
        .S_AWADDR(S_AWADDR), .S_AWATTR(S_AWATTR),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID),
        .M_AWADDR(M_AWADDR), .M_AWATTR(M_AWATTR),
        .ORD_VALID(ORD_VALID), .ORD_IDX(ORD_IDX), .ORD_POP(ORD_POP),
        .ERR_VLD_DROP(ERR_VLD_DROP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one pending AW (or none), queue of granted indices, RR pointer.
    bit              mv;
    int              midx;
    logic [IW-1:0]   mid;
    logic [AW-1:0]   maddr;
    logic [AT-1:0]   mattr;
    int              rr_m;
    int              ordq[$];
    bit              err_m;

    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic        pop;
        logic        e_mv;
        logic [3:0]  e_srdy;
        logic [5:0]  e_id;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [1:0]  e_oi;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mv = 0; midx = 0; mid = '0; maddr = '0; mattr = '0;
        rr_m = 0; ordq.delete(); err_m = 0;
    endfunction

    function automatic int model_pick();
        bit [NREQ-1:0] elig;
        int            i;
        elig = S_AWVALID;
`ifdef RH_AXI4_AW_ARB_QOS_EN
        begin
            int mq;
            mq = -1;
            for (int r = 0; r < NREQ; r++)
                if (S_AWVALID[r] && int'(S_AWATTR[r*AT+4 +: 4]) > mq) mq = int'(S_AWATTR[r*AT+4 +: 4]);
            for (int r = 0; r < NREQ; r++)
                elig[r] = S_AWVALID[r] && (int'(S_AWATTR[r*AT+4 +: 4]) == mq);
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            i = (rr_m + k) % NREQ;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = (mv && M_AWREADY) ? NREQ'(1 << midx) : '0;
        chk("m_awvalid", 64'(M_AWVALID), 64'(mv));
        chk("m_awid", 64'(M_AWID), 64'((midx << IW) | int'(mid)));
        chk("m_awaddr", 64'(M_AWADDR), 64'(maddr));
        chk("m_awattr", 64'(M_AWATTR), 64'(mattr));
        chk("s_awready", 64'(S_AWREADY), 64'(exp_rdy));
        chk("ord_valid", 64'(ORD_VALID), 64'(ordq.size() > 0));
        if (ordq.size() > 0) chk("ord_idx", 64'(ORD_IDX), 64'(ordq[0]));
        chk("err_vld_drop", 64'(ERR_VLD_DROP), 64'(err_m));
    endtask

    task automatic model_update();
        bit pop_ok, do_push;
        int p, pushed;
        pop_ok  = ORD_POP && (ordq.size() > 0);
        do_push = 0;
        pushed  = 0;
        if (mv) begin
            if (!S_AWVALID[midx]) err_m = 1;
            if (M_AWREADY) begin
                mv = 0; do_push = 1; pushed = midx;
                rr_m = (midx + 1) % NREQ;
            end
        end else if (ordq.size() < DEP) begin
            p = model_pick();
            if (p >= 0) begin
                mv = 1; midx = p;
                mid   = S_AWID[p*IW +: IW];
                maddr = S_AWADDR[p*AW +: AW];
                mattr = S_AWATTR[p*AT +: AT];
            end
        end
        if (pop_ok) void'(ordq.pop_front());
        if (do_push) ordq.push_back(pushed);
    endtask

    task automatic cyc();
        @(negedge ACLK);
        model_check();
        model_update();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        S_AWVALID = '0; M_AWREADY = 1'b0; ORD_POP = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk("rst_m_awvalid", 64'(M_AWVALID), 64'd0);
        chk("rst_m_awid", 64'(M_AWID), 64'd0);
        chk("rst_m_awaddr", 64'(M_AWADDR), 64'd0);
        chk("rst_m_awattr", 64'(M_AWATTR), 64'd0);
        chk("rst_s_awready", 64'(S_AWREADY), 64'd0);
        chk("rst_ord_valid", 64'(ORD_VALID), 64'd0);
        chk("rst_ord_idx", 64'(ORD_IDX), 64'd0);
        chk("rst_err", 64'(ERR_VLD_DROP), 64'd0);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_pl(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [AT-1:0] attr);
        S_AWID[i*IW +: IW]   = id;
        S_AWADDR[i*AW +: AW] = addr;
        S_AWATTR[i*AT +: AT] = attr;
    endtask

    task automatic rand_pl();
        for (int i = 0; i < NREQ; i++)
            set_pl(i, IW'($urandom), AW'($urandom), AT'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   got[$];
        int   exp_order[5];
        int   n;

        ARESETN = 1'b0; S_AWVALID = '0; M_AWREADY = 1'b0; ORD_POP = 1'b0;
        S_AWID = '0; S_AWADDR = '0; S_AWATTR = '0;
        model_reset();
        repeat (2) @(posedge ACLK);
        do_reset();

        // Single request from requester 2: ID=5, ADDR=0x1000, LEN=3.
        tbl[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h00, 32'h0,    1'b0, 2'd0};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 6'h25, 32'h1000, 1'b0, 2'd0};
        tbl[2] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 6'h25, 32'h1000, 1'b1, 2'd2};
        tbl[3] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 6'h25, 32'h1000, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 6'h25, 32'h1000, 1'b0, 2'd0};
        set_pl(2, 4'h5, 32'h1000, AT'(3 << 21));
        for (int v = 0; v < 5; v++) begin
            S_AWVALID = tbl[v].valid; M_AWREADY = tbl[v].ready; ORD_POP = tbl[v].pop;
            #1;
            chk("tbl_m_awvalid", 64'(M_AWVALID), 64'(tbl[v].e_mv));
            chk("tbl_s_awready", 64'(S_AWREADY), 64'(tbl[v].e_srdy));
            chk("tbl_ord_valid", 64'(ORD_VALID), 64'(tbl[v].e_ov));
            if (tbl[v].e_mv) begin
                chk("tbl_m_awid", 64'(M_AWID), 64'(tbl[v].e_id));
                chk("tbl_m_awaddr", 64'(M_AWADDR), 64'(tbl[v].e_addr));
                chk("tbl_m_awlen", 64'(M_AWATTR[28:21]), 64'd3);
            end
            if (tbl[v].e_ov) chk("tbl_ord_idx", 64'(ORD_IDX), 64'(tbl[v].e_oi));
            cyc();
        end

        // All requesters valid: grants 0,1,2,3,0 on alternate cycles.
        do_reset();
        rand_pl();
        S_AWVALID = 4'b1111; M_AWREADY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("rr_alt_valid", 64'(M_AWVALID), 64'(k % 2));
            if (M_AWVALID) got.push_back(int'(M_AWID[IW+NW-1:IW]));
            cyc();
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_grant_count", 64'(got.size()), 64'd5);
        for (int j = 0; j < 5 && j < got.size(); j++) chk("rr_grant_order", 64'(got[j]), 64'(exp_order[j]));
        S_AWVALID = '0;
        for (int j = 0; j < 5; j++) begin
            ORD_POP = 1'b1;
            chk("rr_fifo_valid", 64'(ORD_VALID), 64'd1);
            chk("rr_fifo_order", 64'(ORD_IDX), 64'(exp_order[j]));
            cyc();
        end
        ORD_POP = 1'b0;
        chk("rr_fifo_drained", 64'(ORD_VALID), 64'd0);

        // Backpressure: payload frozen for 5 cycles while the source payload changes.
        do_reset();
        set_pl(1, 4'hA, 32'h2000, AT'(29'h1ABCDE));
        S_AWVALID = 4'b0010; M_AWREADY = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_m_awvalid", 64'(M_AWVALID), 64'd1);
            chk("bp_m_awaddr", 64'(M_AWADDR), 64'h2000);
            chk("bp_m_awid", 64'(M_AWID), 64'h1A);
            chk("bp_s_awready", 64'(S_AWREADY), 64'd0);
            set_pl(1, IW'($urandom), AW'($urandom), AT'($urandom));
            cyc();
        end
        M_AWREADY = 1'b1;
        #1;
        chk("bp_s_awready_pulse", 64'(S_AWREADY), 64'b0010);
        cyc();
        S_AWVALID = '0; M_AWREADY = 1'b0;
        chk("bp_one_push_valid", 64'(ORD_VALID), 64'd1);
        chk("bp_one_push_idx", 64'(ORD_IDX), 64'd1);
        ORD_POP = 1'b1;
        cyc();
        ORD_POP = 1'b0;
        chk("bp_one_push_only", 64'(ORD_VALID), 64'd0);

        // FIFO full blocks grants; push with pop keeps occupancy.
        do_reset();
        rand_pl();
        S_AWVALID = 4'b1111; M_AWREADY = 1'b1;
        for (int k = 0; k < 16; k++) cyc();
        for (int k = 0; k < 6; k++) begin
            chk("full_no_grant", 64'(M_AWVALID), 64'd0);
            cyc();
        end
        ORD_POP = 1'b1; cyc(); ORD_POP = 1'b0;
        chk("full_pop_no_grant", 64'(M_AWVALID), 64'd0);
        cyc();
        chk("after_pop_grant", 64'(M_AWVALID), 64'd1);
        ORD_POP = 1'b1; cyc(); ORD_POP = 1'b0;
        chk("pushpop_regrant_idle", 64'(M_AWVALID), 64'd0);
        cyc();
        chk("pushpop_regrant", 64'(M_AWVALID), 64'd1);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("refull_no_grant", 64'(M_AWVALID), 64'd0);
            cyc();
        end
        S_AWVALID = '0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (ORD_VALID) begin ORD_POP = 1'b1; n++; end
            else ORD_POP = 1'b0;
            cyc();
        end
        ORD_POP = 1'b0;
        chk("drain_count", 64'(n), 64'd8);
        ORD_POP = 1'b1; cyc(); cyc(); ORD_POP = 1'b0;
        chk("pop_empty_ignored", 64'(ORD_VALID), 64'd0);
        S_AWVALID = 4'b0100; M_AWREADY = 1'b1;
        cyc(); cyc();
        S_AWVALID = '0;
        chk("post_empty_pop_valid", 64'(ORD_VALID), 64'd1);
        chk("post_empty_pop_idx", 64'(ORD_IDX), 64'd2);
        ORD_POP = 1'b1; cyc(); ORD_POP = 1'b0;

        // Granted requester drops AWVALID in HOLD.
        do_reset();
        set_pl(0, 4'h3, 32'hDEAD0000, AT'(29'h00F0F0));
        S_AWVALID = 4'b0001; M_AWREADY = 1'b0;
        cyc();
        S_AWVALID = '0;
        chk("drop_err_before", 64'(ERR_VLD_DROP), 64'd0);
        cyc();
        chk("drop_still_valid", 64'(M_AWVALID), 64'd1);
        chk("drop_err_set", 64'(ERR_VLD_DROP), 64'd1);
        chk("drop_addr", 64'(M_AWADDR), 64'hDEAD0000);
        M_AWREADY = 1'b1;
        #1;
        chk("drop_s_awready", 64'(S_AWREADY), 64'b0001);
        cyc();
        M_AWREADY = 1'b0;
        chk("drop_done", 64'(M_AWVALID), 64'd0);
        chk("drop_ord_idx", 64'(ORD_IDX), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("drop_err_sticky", 64'(ERR_VLD_DROP), 64'd1);
            cyc();
        end
        S_AWVALID = 4'b0010;
        cyc();
        chk("midhold_valid", 64'(M_AWVALID), 64'd1);
        do_reset();

        // QOS: req0 QOS=1, req3 QOS=9.
        set_pl(0, 4'h1, 32'hA0, AT'(1 << 4));
        set_pl(3, 4'h2, 32'hB0, AT'(9 << 4));
        S_AWVALID = 4'b1001; M_AWREADY = 1'b1;
        cyc();
`ifdef RH_AXI4_AW_ARB_QOS_EN
        chk("qos_grant_idx", 64'(M_AWID[IW+NW-1:IW]), 64'd3);
        chk("qos_grant_addr", 64'(M_AWADDR), 64'hB0);
`else
        chk("qos_grant_idx", 64'(M_AWID[IW+NW-1:IW]), 64'd0);
        chk("qos_grant_addr", 64'(M_AWADDR), 64'hA0);
`endif
        cyc();
        S_AWVALID = '0;
        cyc();

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            S_AWVALID = NREQ'($urandom);
            M_AWREADY = ($urandom % 4) != 0;
            ORD_POP   = ($urandom % 3) == 0;
            rand_pl();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
